// File: rtl/modn_period_checker.sv
// Measures the interval of a mod-N wrap pulse, locks after LOCK_CNT matches and flags violations while locked.
// All outputs registered (1-cycle latency), no backpressure; `define MODN_CHK_ERRCNT_EN adds the saturating err counter.
module modn_period_checker #(
  parameter int N        = 6,
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [WIDTH-1:0] period,
  output logic             period_vld,
  output logic             lock,
  output logic             err,
  output logic [7:0]       err_count
);

  // Match count clears on lock, so it only has to hold 0..LOCK_CNT-1.
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [WIDTH-1:0] N_W        = WIDTH'(N);
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [MW-1:0]    LAST_MATCH = MW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] icnt_q, icnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    err_d        = 1'b0;

    if (tick) begin
      icnt_d = WIDTH'(1);
    end else if (icnt_q == CNT_MAX) begin
      icnt_d = icnt_q;
    end else begin
      icnt_d = icnt_q + WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_ACQUIRE;
        end
      end

      S_ACQUIRE: begin
        if (tick) begin
          period_d     = icnt_q;
          period_vld_d = 1'b1;
          if (icnt_q == N_W) begin
            if (match_q == LAST_MATCH) begin
              state_d = S_LOCKED;
              match_d = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
      end

      S_LOCKED: begin
        if (tick) begin
          period_d     = icnt_q;
          period_vld_d = 1'b1;
          err_d        = (icnt_q != N_W);
        end else begin
          // Reaching N without a tick means the tick went missing.
          err_d = (icnt_q == N_W);
        end
        if (err_d) begin
          state_d = S_ACQUIRE;
          match_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        match_d = '0;
      end
    endcase

    lock_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      icnt_q       <= '0;
      match_q      <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      icnt_q       <= icnt_d;
      match_q      <= match_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
    end
  end

  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign lock       = lock_q;
  assign err        = err_q;

`ifdef MODN_CHK_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/modn_period_checker.md
MODN_PERIOD_CHECKER -- requirements
Module: modn_period_checker

Interface
REQ-001 SHALL have parameter N, default 6: expected tick period in clk cycles (N >= 2).
REQ-002 SHALL have parameter WIDTH, default 8: interval counter and period width (2^WIDTH-1 > N).
REQ-003 SHALL have parameter LOCK_CNT, default 4: consecutive matching intervals required to lock (>= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port tick  input  1  wrap pulse from a mod-N counter, sampled every clk cycle.
REQ-007 SHALL have port period  output  WIDTH  last measured tick-to-tick interval.
REQ-008 SHALL have port period_vld  output  1  one-cycle pulse when period is updated.
REQ-009 SHALL have port lock  output  1  high while in LOCKED.
REQ-010 SHALL have port err  output  1  one-cycle pulse on period violation in LOCKED.
REQ-011 SHALL have port err_count  output  8  saturating count of err pulses.

Function
REQ-012 SHALL keep interval counter icnt: on tick, icnt <= 1; otherwise icnt <= icnt+1, saturating at 2^WIDTH-1.
REQ-013 SHALL define measured interval as the icnt value in the tick cycle (ticks at cycles t0, t1 -> interval t1-t0).
REQ-014 SHALL implement states IDLE, ACQUIRE, LOCKED; IDLE after reset.
REQ-015 IDLE: first tick SHALL move to ACQUIRE with no measurement, no period_vld.
REQ-016 ACQUIRE/LOCKED: each tick SHALL register period <= interval and pulse period_vld the following cycle.
REQ-017 ACQUIRE: tick with interval == N SHALL increment match count; at LOCK_CNT matches SHALL enter LOCKED (lock high next cycle).
REQ-018 ACQUIRE: tick with interval != N SHALL clear match count and remain in ACQUIRE; err SHALL NOT pulse.
REQ-019 LOCKED: tick with interval != N SHALL pulse err next cycle, drop lock, clear match count, enter ACQUIRE.
REQ-020 LOCKED: icnt == N with tick low (missing tick) SHALL pulse err next cycle, drop lock, clear match count, enter ACQUIRE.
REQ-021 A later tick after a missing-tick error SHALL be measured normally (interval > N, counts as mismatch in ACQUIRE).
REQ-022 Tick in the cycle icnt == N SHALL be a match, never a timeout.
REQ-023 All outputs SHALL be registered; latency from sampled tick to output change is one cycle.

Reset
REQ-024 rst SHALL take priority over tick in the same cycle.
REQ-025 On rst: state IDLE, icnt 0, match count 0, period 0, period_vld 0, lock 0, err 0, err_count 0, effective next cycle.
REQ-026 rst mid-LOCKED SHALL drop lock without pulsing err.

Configuration
REQ-027 Macro MODN_CHK_ERRCNT_EN defined: err_count SHALL increment on every err pulse, saturating at 255.
REQ-028 Macro MODN_CHK_ERRCNT_EN undefined: err_count port SHALL remain present, tied to 0, no counter logic.

Verification
REQ-029 N=6, LOCK_CNT=4, tick every 6 cycles -> no period_vld after 1st tick; period=6 from 2nd tick; lock=1 one cycle after 5th tick.
REQ-030 Locked, next tick after 5 cycles -> period=5, err one-cycle pulse, lock=0, relock after 4 further 6-cycle intervals.
REQ-031 Locked, tick at t0 then none -> err at t0+7, lock=0 at t0+7; tick at t0+9 -> period=9, no err.
REQ-032 WIDTH=8, ticks 400 cycles apart -> period=255 (saturated), lock stays 0.
REQ-033 rst asserted while locked, tick same cycle -> next cycle lock=0, err=0, period=0, state IDLE; following tick gives no period_vld.
REQ-034 Three locked-state errors -> err_count=3 with MODN_CHK_ERRCNT_EN, 0 without; 300 errors -> 255 with macro.
